// File: rtl/pktchain_pkg.sv
// Shared definitions for the packetized configuration chain endpoint.
// Header fields sit at fixed offsets measured down from the phit MSB.
package pktchain_pkg;

  localparam logic [7:0] MSG_DATA = 8'h01;
  localparam logic [7:0] MSG_DONE = 8'h02;

  localparam int FIELD_W  = 8;
  localparam int TYPE_OFS = 0;   // offsets below the phit MSB
  localparam int LEN_OFS  = 8;
  localparam int HOP_OFS  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_PROG_WAIT,
    ST_PROG_SHIFT,
    ST_DROP
  } state_e;

endpackage

// File: rtl/pktchain_phit_buf.sv
// One-entry valid/ready register slice for the downstream phit path.
// Accepts a new phit in the same cycle the held one drains.
module pktchain_phit_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pktchain_clasp.sv
// Per-tile packet endpoint: consumes local packets into the config chain or forwards them.
// Optional PKTCHAIN_ERRCNT_EN adds an 8-bit saturating unknown-type counter (err_count).
module pktchain_clasp #(
  parameter int PHIT_WIDTH = 32,
  parameter int CFG_WIDTH  = 1
) (
  input  logic                  cfg_clk,
  input  logic                  cfg_rst,
  input  logic                  phit_i_valid,
  input  logic [PHIT_WIDTH-1:0] phit_i,
  output logic                  phit_i_ready,
  output logic                  phit_o_valid,
  output logic [PHIT_WIDTH-1:0] phit_o,
  input  logic                  phit_o_ready,
  output logic                  cfg_we,
  output logic [CFG_WIDTH-1:0]  cfg_o,
  output logic                  programmed
`ifdef PKTCHAIN_ERRCNT_EN
  ,
  output logic [7:0]            err_count
`endif
);
  import pktchain_pkg::*;

  localparam int SHIFTS = PHIT_WIDTH / CFG_WIDTH;
  localparam int CNT_W  = $clog2(SHIFTS + 1);

  state_e                state_q, state_d;
  logic [7:0]            remaining_q, remaining_d;
  logic [CNT_W-1:0]      shift_cnt_q, shift_cnt_d;
  logic [PHIT_WIDTH-1:0] sr_q, sr_d;
  logic                  programmed_q, programmed_d;
  logic                  active_q;

  logic [7:0]            hdr_type, hdr_len, hdr_hop;
  logic [PHIT_WIDTH-1:0] fwd_hdr;
  logic                  in_ready, accept;
  logic                  buf_in_valid, buf_in_ready;
  logic [PHIT_WIDTH-1:0] buf_in_data;

  assign hdr_type = phit_i[PHIT_WIDTH-1-TYPE_OFS -: FIELD_W];
  assign hdr_len  = phit_i[PHIT_WIDTH-1-LEN_OFS  -: FIELD_W];
  assign hdr_hop  = phit_i[PHIT_WIDTH-1-HOP_OFS  -: FIELD_W];

  always_comb begin
    fwd_hdr = phit_i;
    fwd_hdr[PHIT_WIDTH-1-HOP_OFS -: FIELD_W] = hdr_hop - 8'd1;
  end

  assign phit_i_ready = in_ready;
  assign accept       = phit_i_valid && in_ready;
  assign cfg_we       = (state_q == ST_PROG_SHIFT);
  assign cfg_o        = sr_q[PHIT_WIDTH-1 -: CFG_WIDTH];
  assign programmed   = programmed_q;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    shift_cnt_d  = shift_cnt_q;
    sr_d         = sr_q;
    programmed_d = programmed_q;
    in_ready     = 1'b0;
    buf_in_valid = 1'b0;
    buf_in_data  = phit_i;
    case (state_q)
      ST_IDLE: begin
        // Local headers never wait on a stalled downstream buffer.
        in_ready = active_q && (buf_in_ready || hdr_hop == '0);
        if (accept) begin
          remaining_d = hdr_len;
          if (hdr_hop != '0) begin
            buf_in_valid = 1'b1;
            buf_in_data  = fwd_hdr;
            if (hdr_len != '0) state_d = ST_FWD;
          end else if (hdr_type == MSG_DATA) begin
            if (hdr_len != '0) state_d = ST_PROG_WAIT;
          end else begin
            if (hdr_type == MSG_DONE) programmed_d = 1'b1;
            if (hdr_len != '0) state_d = ST_DROP;
          end
        end
      end
      ST_FWD: begin
        in_ready = buf_in_ready;
        if (accept) begin
          buf_in_valid = 1'b1;
          remaining_d  = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = ST_IDLE;
        end
      end
      ST_PROG_WAIT: begin
        in_ready = 1'b1;
        if (accept) begin
          sr_d        = phit_i;
          shift_cnt_d = CNT_W'(SHIFTS);
          remaining_d = remaining_q - 8'd1;
          state_d     = ST_PROG_SHIFT;
        end
      end
      ST_PROG_SHIFT: begin
        sr_d        = sr_q << CFG_WIDTH;
        shift_cnt_d = shift_cnt_q - 1'b1;
        if (shift_cnt_q == CNT_W'(1))
          state_d = (remaining_q == '0) ? ST_IDLE : ST_PROG_WAIT;
      end
      ST_DROP: begin
        in_ready = 1'b1;
        if (accept) begin
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cfg_clk or posedge cfg_rst) begin
    if (cfg_rst) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      shift_cnt_q  <= '0;
      sr_q         <= '0;
      programmed_q <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      shift_cnt_q  <= shift_cnt_d;
      sr_q         <= sr_d;
      programmed_q <= programmed_d;
      active_q     <= 1'b1;
    end
  end

`ifdef PKTCHAIN_ERRCNT_EN
  logic [7:0] err_q, err_d;
  logic       err_hit;

  assign err_hit   = (state_q == ST_IDLE) && accept && (hdr_hop == '0) &&
                     (hdr_type != MSG_DATA) && (hdr_type != MSG_DONE);
  assign err_count = err_q;

  always_comb begin
    err_d = err_q;
    if (err_hit && err_q != '1) err_d = err_q + 8'd1;
  end

  always_ff @(posedge cfg_clk or posedge cfg_rst) begin
    if (cfg_rst) err_q <= '0;
    else         err_q <= err_d;
  end
`endif

  pktchain_phit_buf #(
    .WIDTH(PHIT_WIDTH)
  ) u_out_buf (
    .clk      (cfg_clk),
    .rst      (cfg_rst),
    .in_valid (buf_in_valid),
    .in_data  (buf_in_data),
    .in_ready (buf_in_ready),
    .out_valid(phit_o_valid),
    .out_data (phit_o),
    .out_ready(phit_o_ready)
  );

endmodule
